// File: rtl/ex_muldiv_if.sv
// Handshake bundle between the ID/EX register, the iterative mul/div unit and EX/MEM.
// The master side drives the instruction and flush; the slave side returns stall and result.
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [4:0]      in_wd;
  logic            in_wreg;
  logic            stall_req;
  logic            out_valid;
  logic [XLEN-1:0] out_wdata;
  logic [4:0]      out_wd;
  logic            out_wreg;

  modport master (
    output flush, in_valid, in_funct3, in_rs1, in_rs2, in_wd, in_wreg,
    input  stall_req, out_valid, out_wdata, out_wd, out_wreg
  );

  modport slave (
    input  flush, in_valid, in_funct3, in_rs1, in_rs2, in_wd, in_wreg,
    output stall_req, out_valid, out_wdata, out_wd, out_wreg
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiplier and restoring divider,
// one bit per cycle on operand magnitudes, sign fixed up when the result is formed.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  ex_muldiv_if.slave  bus
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
  logic [2:0]      f3_q, f3_d;
  logic [4:0]      wd_q, wd_d;
  logic            wreg_q, wreg_d, negq_q, negq_d, negr_q, negr_d;
  logic [XLEN-1:0] res_d;
  logic            stall;

  logic            out_valid_q, out_wreg_q;
  logic [XLEN-1:0] out_wdata_q;
  logic [4:0]      out_wd_q;

  logic signed [XLEN-1:0] rs1_s, rs2_s;
  logic            sgn1, sgn2, s1, s2;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN:0]   sum, shifted, diff;
  logic            ge;

  function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] v);
    return n ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] finish_mul(input logic [2:0] f3, input logic n,
                                                 input logic [2*XLEN-1:0] p);
    logic [2*XLEN-1:0] s;
    s = n ? -p : p;
    return (f3[1:0] == 2'b00) ? s[XLEN-1:0] : s[2*XLEN-1:XLEN];
  endfunction

  function automatic logic [XLEN-1:0] finish_div(input logic [2:0] f3, input logic nq,
                                                 input logic nr, input logic [XLEN-1:0] q,
                                                 input logic [XLEN-1:0] r);
    return f3[1] ? neg_if(nr, r) : neg_if(nq, q);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    f3_d    = f3_q;
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    res_d   = '0;
    stall   = 1'b0;

    rs1_s = bus.in_rs1;
    rs2_s = bus.in_rs2;
    sgn1  = (bus.in_funct3 == 3'd1) || (bus.in_funct3 == 3'd2) ||
            (bus.in_funct3 == 3'd4) || (bus.in_funct3 == 3'd6);
    sgn2  = (bus.in_funct3 == 3'd1) || (bus.in_funct3 == 3'd4) || (bus.in_funct3 == 3'd6);
    s1    = sgn1 && (rs1_s < 0);
    s2    = sgn2 && (rs2_s < 0);
    a_abs = neg_if(s1, bus.in_rs1);
    b_abs = neg_if(s2, bus.in_rs2);

    // Multiply step: conditional add into the high half, then shift the product right.
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    // Divide step: shift next dividend bit into the partial remainder and trial-subtract.
    shifted = {hi_q, lo_q[XLEN-1]};
    diff    = shifted - {1'b0, opb_q};
    ge      = (shifted >= {1'b0, opb_q});

    case (state_q)
      IDLE: begin
        if (bus.in_valid && !bus.flush) begin
          stall  = 1'b1;
          f3_d   = bus.in_funct3;
          wd_d   = bus.in_wd;
          wreg_d = bus.in_wreg;
          negq_d = s1 ^ s2;
          negr_d = s1;
          hi_d   = '0;
          cnt_d  = '0;
          lo_d   = bus.in_funct3[2] ? a_abs : b_abs;
          opb_d  = bus.in_funct3[2] ? b_abs : a_abs;
          if (bus.in_funct3[2] && (bus.in_rs2 == '0)) begin
            res_d   = bus.in_funct3[1] ? bus.in_rs1 : '1;
            state_d = DONE;
          end else if (bus.in_funct3[2] && !bus.in_funct3[0] &&
                       (bus.in_rs1 == SMIN) && (bus.in_rs2 == '1)) begin
            res_d   = bus.in_funct3[1] ? '0 : SMIN;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        stall = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (f3_q[2]) begin
          hi_d = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], ge};
        end else begin
          hi_d = sum[XLEN:1];
          lo_d = {sum[0], lo_q[XLEN-1:1]};
        end
        res_d = f3_q[2] ? finish_div(f3_q, negq_q, negr_q, lo_d, hi_d)
                        : finish_mul(f3_q, negq_q, {hi_d, lo_d});
        if (cnt_q == CW'(XLEN-1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (bus.flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_wreg_q  <= 1'b0;
      out_wdata_q <= '0;
      out_wd_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= (state_d == DONE);
      out_wreg_q  <= (state_d == DONE) && wreg_d;
      if (state_d == DONE) begin
        out_wdata_q <= res_d;
        out_wd_q    <= wd_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    hi_q   <= hi_d;
    lo_q   <= lo_d;
    opb_q  <= opb_d;
    f3_q   <= f3_d;
    wd_q   <= wd_d;
    wreg_q <= wreg_d;
    negq_q <= negq_d;
    negr_q <= negr_d;
  end

  assign bus.stall_req = stall;
  assign bus.out_valid = out_valid_q;
  assign bus.out_wdata = out_wdata_q;
  assign bus.out_wd    = out_wd_q;
  assign bus.out_wreg  = out_wreg_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: results, stall length, result-beat shape, flush/reset abort
// and back-to-back issue, with hand-computed expected values.
module tb_ex_muldiv;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ex_muldiv_if #(.XLEN(32)) bus ();
  ex_muldiv #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Issue one op, hold in_valid while stalled and through the result beat, then drop it
  // and observe one further cycle.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wd, input logic wreg,
                        output int stalls, output int vcnt, output logic [31:0] data,
                        output logic [4:0] owd, output logic owreg);
    logic seen;
    @(negedge clk);
    bus.in_funct3 = f3; bus.in_rs1 = a; bus.in_rs2 = b;
    bus.in_wd = wd; bus.in_wreg = wreg; bus.in_valid = 1'b1;
    stalls = 0; vcnt = 0; data = '0; owd = '0; owreg = 1'b0; seen = 1'b0;
    for (int k = 0; k < 80; k++) begin
      #1;
      if (bus.stall_req) stalls++;
      if (bus.out_valid) begin
        vcnt++; data = bus.out_wdata; owd = bus.out_wd; owreg = bus.out_wreg; seen = 1'b1;
      end
      @(negedge clk);
      if (seen) break;
    end
    bus.in_valid = 1'b0;
    #1;
    if (bus.stall_req) stalls++;
    if (bus.out_valid) vcnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_funct3 = '0;
    bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_wd = '0; bus.in_wreg = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.out_wreg, bus.out_wd, bus.out_wdata} !== '0) begin
      errors++;
      $display("FAIL reset outputs: valid=%b wreg=%b wd=%h wdata=%h, all must be 0",
               bus.out_valid, bus.out_wreg, bus.out_wd, bus.out_wdata);
    end
    checks++;
    if (bus.stall_req !== 1'b0) begin
      errors++; $display("FAIL reset stall_req: got %b expected 0", bus.stall_req);
    end
    rst = 1'b0;
  endtask

  task automatic test_mul();
    logic [2:0]  vf [6] = '{3'd0, 3'd0, 3'd1, 3'd3, 3'd2, 3'd1};
    logic [31:0] va [6] = '{32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] vb [6] = '{32'd6, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'h80000000};
    logic [31:0] ve [6] = '{32'd42, 32'hFFFFFFF1, 32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000};
    int st, vc; logic [31:0] d; logic [4:0] w; logic we;
    for (int i = 0; i < 6; i++) begin
      run_op(vf[i], va[i], vb[i], 5'(i + 1), i[0] == 1'b0, st, vc, d, w, we);
      checks++;
      if (d !== ve[i]) begin errors++; $display("FAIL mul[%0d] data: got %h expected %h", i, d, ve[i]); end
      checks++;
      if (st !== 33) begin errors++; $display("FAIL mul[%0d] stall cycles: got %0d expected 33", i, st); end
      checks++;
      if (vc !== 1) begin errors++; $display("FAIL mul[%0d] out_valid beats: got %0d expected 1", i, vc); end
      checks++;
      if ({w, we} !== {5'(i + 1), i[0] == 1'b0}) begin
        errors++; $display("FAIL mul[%0d] wd/wreg: got %h/%b expected %h/%b", i, w, we, 5'(i + 1), i[0] == 1'b0);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  vf [7] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd7};
    logic [31:0] va [7] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7, 32'h80000000};
    logic [31:0] vb [7] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF};
    logic [31:0] ve [7] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1, 32'h80000000};
    int st, vc; logic [31:0] d; logic [4:0] w; logic we;
    for (int i = 0; i < 7; i++) begin
      run_op(vf[i], va[i], vb[i], 5'(i + 10), 1'b1, st, vc, d, w, we);
      checks++;
      if (d !== ve[i]) begin errors++; $display("FAIL div[%0d] data: got %h expected %h", i, d, ve[i]); end
      checks++;
      if (st !== 33) begin errors++; $display("FAIL div[%0d] stall cycles: got %0d expected 33", i, st); end
      checks++;
      if (vc !== 1) begin errors++; $display("FAIL div[%0d] out_valid beats: got %0d expected 1", i, vc); end
      checks++;
      if ({w, we} !== {5'(i + 10), 1'b1}) begin
        errors++; $display("FAIL div[%0d] wd/wreg: got %h/%b expected %h/1", i, w, we, 5'(i + 10));
      end
    end
  endtask

  task automatic test_special();
    logic [2:0]  vf [5] = '{3'd4, 3'd6, 3'd4, 3'd6, 3'd5};
    logic [31:0] va [5] = '{32'd1234, 32'd5, 32'h80000000, 32'h80000000, 32'd9};
    logic [31:0] vb [5] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
    logic [31:0] ve [5] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'hFFFFFFFF};
    int st, vc; logic [31:0] d; logic [4:0] w; logic we;
    for (int i = 0; i < 5; i++) begin
      run_op(vf[i], va[i], vb[i], 5'(i + 20), 1'b1, st, vc, d, w, we);
      checks++;
      if (d !== ve[i]) begin errors++; $display("FAIL special[%0d] data: got %h expected %h", i, d, ve[i]); end
      checks++;
      if (st !== 1) begin errors++; $display("FAIL special[%0d] stall cycles: got %0d expected 1", i, st); end
      checks++;
      if (vc !== 1) begin errors++; $display("FAIL special[%0d] out_valid beats: got %0d expected 1", i, vc); end
      checks++;
      if (w !== 5'(i + 20)) begin errors++; $display("FAIL special[%0d] wd: got %h expected %h", i, w, 5'(i + 20)); end
    end
  endtask

  task automatic test_flush();
    int st, vc; logic [31:0] d; logic [4:0] w; logic we; logic seen;
    @(negedge clk);
    bus.in_funct3 = 3'd0; bus.in_rs1 = 32'd7; bus.in_rs2 = 32'd6;
    bus.in_wd = 5'd5; bus.in_wreg = 1'b1; bus.in_valid = 1'b1;
    repeat (11) @(negedge clk);
    bus.flush = 1'b1; bus.in_valid = 1'b0;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    checks++;
    if ({bus.stall_req, bus.out_valid} !== 2'b00) begin
      errors++; $display("FAIL flush stall/valid: got %b%b expected 00", bus.stall_req, bus.out_valid);
    end
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (bus.out_valid) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL flush result suppressed: got valid=%b expected 0", seen); end

    // Flush in IDLE wins over a simultaneous in_valid.
    @(negedge clk);
    bus.in_funct3 = 3'd4; bus.in_rs1 = 32'd10; bus.in_rs2 = 32'd2; bus.in_valid = 1'b1; bus.flush = 1'b1;
    #1;
    checks++;
    if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL flush-idle stall_req: got %b expected 0", bus.stall_req); end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (bus.out_valid) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL flush-idle not accepted: got valid=%b expected 0", seen); end

    run_op(3'd5, 32'd9, 32'd3, 5'd17, 1'b1, st, vc, d, w, we);
    checks++;
    if (d !== 32'd3) begin errors++; $display("FAIL post-flush divu data: got %h expected 3", d); end
    checks++;
    if ((st !== 33) || (vc !== 1)) begin
      errors++; $display("FAIL post-flush divu timing: got stalls=%0d beats=%0d expected 33/1", st, vc);
    end
  endtask

  task automatic test_rst_mid();
    logic seen;
    @(negedge clk);
    bus.in_funct3 = 3'd0; bus.in_rs1 = 32'd7; bus.in_rs2 = 32'd6;
    bus.in_wd = 5'd9; bus.in_wreg = 1'b1; bus.in_valid = 1'b1;
    repeat (15) @(negedge clk);
    rst = 1'b1; bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({bus.stall_req, bus.out_valid, bus.out_wreg, bus.out_wd, bus.out_wdata} !== '0) begin
      errors++;
      $display("FAIL rst mid-calc outputs: stall=%b valid=%b wreg=%b wd=%h wdata=%h, all must be 0",
               bus.stall_req, bus.out_valid, bus.out_wreg, bus.out_wd, bus.out_wdata);
    end
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (bus.out_valid) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rst mid-calc result discarded: got valid=%b expected 0", seen); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0; int t1 = -1; int t2 = -1; logic [31:0] d1 = '0, d2 = '0; logic extra;
    @(negedge clk);
    bus.in_funct3 = 3'd0; bus.in_rs1 = 32'd7; bus.in_rs2 = 32'd6;
    bus.in_wd = 5'd3; bus.in_wreg = 1'b1; bus.in_valid = 1'b1;
    for (int cyc = 0; cyc < 120 && pulses < 2; cyc++) begin
      #1;
      if (bus.out_valid) begin
        pulses++;
        if (pulses == 1) begin
          t1 = cyc; d1 = bus.out_wdata; bus.in_rs1 = 32'd9; bus.in_rs2 = 32'd9;
        end else begin
          t2 = cyc; d2 = bus.out_wdata; bus.in_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    extra = 1'b0;
    repeat (40) begin #1; if (bus.out_valid) extra = 1'b1; @(negedge clk); end
    checks++;
    if (pulses !== 2) begin errors++; $display("FAIL b2b pulse count: got %0d expected 2", pulses); end
    checks++;
    if ((t2 - t1) !== 34) begin errors++; $display("FAIL b2b pulse spacing: got %0d expected 34", t2 - t1); end
    checks++;
    if ({d1, d2} !== {32'd42, 32'd81}) begin
      errors++; $display("FAIL b2b data: got %h,%h expected 0000002a,00000051", d1, d2);
    end
    checks++;
    if (extra !== 1'b0) begin errors++; $display("FAIL b2b no restart: got extra valid=%b expected 0", extra); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_rst_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
